usb_tx_packetizer: RTL and testbench

USB_TX_PACKETIZER -- requirements
Module: usb_tx_packetizer

---
 rtl/usb_tx_packetizer.sv | 176 +++++++++++++++++
 tb/tb_usb_tx_packetizer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_packetizer.sv
// USB full-speed transmit packetizer: SYNC/PID/payload/CRC16 framing with
// bit stuffing, NRZI line coding and EOP generation, one bit time = 4 clk cycles.
module usb_tx_packetizer (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] tx_packet,
   input  logic [7:0] tx_packet_data,
   input  logic [6:0] buffer_occupancy,
   output logic       get_tx_packet_data,
   output logic       dplus_out,
   output logic       dminus_out,
   output logic       tx_transfer_active,
   output logic       tx_error
);

   typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP} state_t;

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_DATA0 = 2'b01;
   localparam logic [1:0] CMD_ACK   = 2'b10;

   state_t      r_state;
   state_t      w_next_state;
   logic [1:0]  r_div;
   logic [2:0]  r_bit_cnt;
   logic [2:0]  r_ones;
   logic [7:0]  r_shift;
   logic [7:0]  r_pid;
   logic [6:0]  r_len;
   logic        r_is_data;
   logic [15:0] r_crc;
   logic        r_level;
   logic        r_tx_error;

   logic        w_cmd_seen;
   logic        w_reject;
   logic        w_start;
   logic        w_bit_end;
   logic        w_stuff;
   logic        w_raw;
   logic        w_byte_end;
   logic        w_line;
   logic        w_pop;
   logic [15:0] w_crc_step;
   logic [15:0] w_crc_next;

   assign w_cmd_seen = (r_state == IDLE) && (tx_packet != CMD_NONE);
   assign w_reject   = w_cmd_seen && (tx_packet == CMD_DATA0) && (buffer_occupancy > 7'd64);
   assign w_start    = w_cmd_seen && !w_reject;
   assign w_bit_end  = (r_div == 2'd3);
   assign w_stuff    = (r_ones == 3'd6);
   assign w_raw      = w_stuff ? 1'b0 : r_shift[0];
   assign w_byte_end = w_bit_end && !w_stuff && (r_bit_cnt == 3'd7);
   // NRZI: r_level is the line level (1 = J) left by the previous bit time
   assign w_line     = w_raw ? r_level : ~r_level;
   assign w_crc_step = (r_crc[0] ^ w_raw) ? ({1'b0, r_crc[15:1]} ^ 16'hA001)
                                          : {1'b0, r_crc[15:1]};
   assign w_crc_next = (r_state == DATA) ? w_crc_step : r_crc;
   assign w_pop      = w_byte_end && (r_len != 7'd0) &&
                       (((r_state == PID) && r_is_data) || (r_state == DATA));

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_start)    w_next_state = SYNC;
         SYNC:    if (w_byte_end) w_next_state = PID;
         PID:     if (w_byte_end) w_next_state = !r_is_data ? EOP :
                                                 (r_len != 7'd0) ? DATA : CRC_LO;
         DATA:    if (w_byte_end && (r_len == 7'd0)) w_next_state = CRC_LO;
         CRC_LO:  if (w_byte_end) w_next_state = CRC_HI;
         CRC_HI:  if (w_byte_end) w_next_state = EOP;
         EOP:     if (w_bit_end && !w_stuff && (r_bit_cnt == 3'd2)) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      tx_transfer_active = (r_state != IDLE);
      get_tx_packet_data = w_pop;
      tx_error           = r_tx_error;
      dplus_out          = 1'b1;
      dminus_out         = 1'b0;
      case (r_state)
         IDLE: begin
         end
         EOP: begin
            // A stuffed bit owed by the last CRC byte goes out before the SE0s
            if (w_stuff) begin
               dplus_out  = w_line;
               dminus_out = ~w_line;
            end else if (r_bit_cnt < 3'd2) begin
               dplus_out  = 1'b0;
               dminus_out = 1'b0;
            end
         end
         default: begin
            dplus_out  = w_line;
            dminus_out = ~w_line;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees pre-edge values regardless of statement order.
      if (rst) begin
         r_div      <= 2'd0;
         r_bit_cnt  <= 3'd0;
         r_ones     <= 3'd0;
         r_shift    <= 8'h00;
         r_pid      <= 8'h00;
         r_len      <= 7'd0;
         r_is_data  <= 1'b0;
         r_crc      <= 16'hFFFF;
         r_level    <= 1'b1;
         r_tx_error <= 1'b0;
      end else begin
         r_tx_error <= w_reject;
         if (r_state == IDLE) begin
            r_level <= 1'b1;
            if (w_start) begin
               r_div     <= 2'd0;
               r_bit_cnt <= 3'd0;
               r_ones    <= 3'd0;
               r_crc     <= 16'hFFFF;
               r_shift   <= 8'h80;
               r_is_data <= (tx_packet == CMD_DATA0);
               r_len     <= (tx_packet == CMD_DATA0) ? buffer_occupancy : 7'd0;
               case (tx_packet)
                  CMD_DATA0: r_pid <= 8'hC3;
                  CMD_ACK:   r_pid <= 8'hD2;
                  default:   r_pid <= 8'h5A;
               endcase
            end
         end else begin
            r_div <= r_div + 2'd1;
            if (w_bit_end) begin
               if ((r_state != EOP) || w_stuff) r_level <= w_line;
               if (w_stuff) begin
                  r_ones <= 3'd0;
               end else if (r_state == EOP) begin
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end else begin
                  r_ones    <= w_raw ? (r_ones + 3'd1) : 3'd0;
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_crc     <= w_crc_next;
                  if (r_bit_cnt == 3'd7) begin
                     case (r_state)
                        SYNC: r_shift <= r_pid;
                        PID, DATA: begin
                           if (r_len != 7'd0) begin
                              r_shift <= tx_packet_data;
                              r_len   <= r_len - 7'd1;
                           end else begin
                              r_shift <= ~w_crc_next[7:0];
                           end
                        end
                        CRC_LO:  r_shift <= ~r_crc[15:8];
                        default: begin
                        end
                     endcase
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Directed bench for usb_tx_packetizer: captures the line per bit time,
// NRZI-decodes and destuffs it, and compares against hand-derived packets.
module tb_usb_tx_packetizer;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] tx_packet;
   logic [7:0] tx_packet_data;
   logic [6:0] buffer_occupancy;
   logic       get_tx_packet_data;
   logic       dplus_out;
   logic       dminus_out;
   logic       tx_transfer_active;
   logic       tx_error;

   localparam logic [1:0] SYM_J = 2'b10, SYM_K = 2'b01, SYM_SE0 = 2'b00;

   int errors = 0;
   int checks = 0;

   logic [7:0] buf_q[$];
   logic [7:0] exp_q[$];
   logic [1:0] cap_syms[$];
   logic [7:0] cap_bytes[$];
   int cap_active, cap_pops, cap_glitch, cap_err, cap_stuffs, cap_bad, cap_timeout;
   logic cap_eop_ok;

   usb_tx_packetizer dut (
      .clk                (clk),
      .rst                (rst),
      .tx_packet          (tx_packet),
      .tx_packet_data     (tx_packet_data),
      .buffer_occupancy   (buffer_occupancy),
      .get_tx_packet_data (get_tx_packet_data),
      .dplus_out          (dplus_out),
      .dminus_out         (dminus_out),
      .tx_transfer_active (tx_transfer_active),
      .tx_error           (tx_error)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] byte_at(input int k);
      return (k < cap_bytes.size()) ? {24'h0, cap_bytes[k]} : 32'hDEAD_BEEF;
   endfunction

   // Byte-wise reflected CRC16 (poly 0x8005, init 0xFFFF), complemented
   function automatic logic [15:0] crc16_2(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] crc;
      crc = 16'hFFFF ^ {8'h00, a};
      for (int i = 0; i < 8; i++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
      crc = crc ^ {8'h00, b};
      for (int i = 0; i < 8; i++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
      return ~crc;
   endfunction

   task automatic set_buf();
      tx_packet_data   = (buf_q.size() != 0) ? buf_q[0] : 8'h00;
      buffer_occupancy = 7'(buf_q.size());
   endtask

   task automatic send_cmd(input logic [1:0] cmd);
      @(negedge clk);
      tx_packet = cmd;
      @(negedge clk);
      tx_packet = 2'b00;
   endtask

   task automatic capture(input int budget);
      int c;
      bit pend;
      logic [1:0] sym, prev;
      logic raw;
      logic [7:0] acc;
      int ones, pos, i;
      cap_syms.delete();
      cap_bytes.delete();
      cap_pops = 0; cap_glitch = 0; cap_err = 0; cap_stuffs = 0; cap_bad = 0;
      cap_timeout = 0;
      c = 0;
      pend = 0;
      while (tx_transfer_active && c < budget) begin
         if (get_tx_packet_data) begin
            cap_pops++;
            pend = 1;
         end
         if (tx_error) cap_err++;
         sym = {dplus_out, dminus_out};
         if (c % 4 == 0) cap_syms.push_back(sym);
         else if (sym !== cap_syms[cap_syms.size()-1]) cap_glitch++;
         c++;
         @(negedge clk);
         if (pend) begin
            void'(buf_q.pop_front());
            set_buf();
            pend = 0;
         end
      end
      cap_active = c;
      if (c >= budget) cap_timeout = 1;
      prev = SYM_J; ones = 0; pos = 0; acc = 8'h00; i = 0;
      while (i < cap_syms.size() && cap_syms[i] != SYM_SE0) begin
         if (cap_syms[i] != SYM_J && cap_syms[i] != SYM_K) cap_bad++;
         raw = (cap_syms[i] == prev);
         prev = cap_syms[i];
         if (ones == 6) begin
            cap_stuffs++;
            if (raw) cap_bad++;
            ones = 0;
         end else begin
            ones = raw ? ones + 1 : 0;
            acc[pos] = raw;
            pos++;
            if (pos == 8) begin
               cap_bytes.push_back(acc);
               pos = 0;
            end
         end
         i++;
      end
      cap_eop_ok = 1'b0;
      if (pos == 0 && cap_syms.size() == i + 3)
         cap_eop_ok = (cap_syms[i] == SYM_SE0) && (cap_syms[i+1] == SYM_SE0) &&
                      (cap_syms[i+2] == SYM_J);
   endtask

   task automatic check_packet(input string name, input int exp_active, input int exp_pops,
                               input int exp_stuffs);
      check({name, "_timeout"}, cap_timeout, 0);
      if (exp_active >= 0) check({name, "_active_cycles"}, cap_active, exp_active);
      check({name, "_pops"}, cap_pops, exp_pops);
      if (exp_stuffs >= 0) check({name, "_stuffs"}, cap_stuffs, exp_stuffs);
      check({name, "_nbytes"}, cap_bytes.size(), exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
         check($sformatf("%s_byte%0d", name, k), byte_at(k), {24'h0, exp_q[k]});
      check({name, "_eop"}, cap_eop_ok, 1);
      check({name, "_stable_bits"}, cap_glitch + cap_bad, 0);
      check({name, "_no_error"}, cap_err, 0);
      check({name, "_idle_J"}, {dplus_out, dminus_out}, SYM_J);
   endtask

   initial begin
      int c;
      int pops_after;
      int active_after;
      int non_j;
      logic [15:0] crc_ab;

      rst = 1'b1;
      tx_packet = 2'b00;
      tx_packet_data = 8'h00;
      buffer_occupancy = 7'd0;
      repeat (3) @(negedge clk);
      check("rst_dplus", dplus_out, 1);
      check("rst_dminus", dminus_out, 0);
      check("rst_active", tx_transfer_active, 0);
      check("rst_pop", get_tx_packet_data, 0);
      check("rst_error", tx_error, 0);
      rst = 1'b0;
      @(negedge clk);

      // ACK: 8 + 8 + 3 bit times
      send_cmd(2'b10);
      capture(1000);
      exp_q = '{8'h80, 8'hD2};
      check_packet("ack", 76, 0, 0);

      send_cmd(2'b11);
      capture(1000);
      exp_q = '{8'h80, 8'h5A};
      check_packet("nak", 76, 0, 0);

      // Zero-length DATA0: CRC field is all zeros
      buf_q.delete();
      set_buf();
      send_cmd(2'b01);
      capture(1000);
      exp_q = '{8'h80, 8'hC3, 8'h00, 8'h00};
      check_packet("data0_len0", 140, 0, 0);

      // One 0xFF byte: CRC remainder 0x00FF -> sent 0xFF00; stuffs in payload and CRC_HI
      buf_q = '{8'hFF};
      set_buf();
      send_cmd(2'b01);
      capture(1000);
      exp_q = '{8'h80, 8'hC3, 8'hFF, 8'h00, 8'hFF};
      check_packet("data0_ff", 180, 1, 2);

      buf_q = '{8'h12, 8'h34};
      set_buf();
      crc_ab = crc16_2(8'h12, 8'h34);
      send_cmd(2'b01);
      capture(2000);
      exp_q = '{8'h80, 8'hC3, 8'h12, 8'h34, crc_ab[7:0], crc_ab[15:8]};
      check_packet("data0_2b", -1, 2, -1);

      // Length limit: 65 rejected with a one-cycle error pulse
      @(negedge clk);
      buffer_occupancy = 7'd65;
      tx_packet = 2'b01;
      @(negedge clk);
      tx_packet = 2'b00;
      check("len65_error_pulse", tx_error, 1);
      check("len65_active", tx_transfer_active, 0);
      check("len65_lines", {dplus_out, dminus_out}, SYM_J);
      @(negedge clk);
      check("len65_error_cleared", tx_error, 0);
      check("len65_still_idle", tx_transfer_active, 0);

      // Length 64 is accepted; abort it with reset
      buffer_occupancy = 7'd64;
      tx_packet = 2'b01;
      @(negedge clk);
      tx_packet = 2'b00;
      check("len64_active", tx_transfer_active, 1);
      check("len64_no_error", tx_error, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("len64_abort_idle", tx_transfer_active, 0);
      @(negedge clk);

      // Busy/reset: NAK during SYNC ignored; first pop at end of PID bit 15
      buf_q = '{8'hA5, 8'h5A};
      set_buf();
      send_cmd(2'b01);
      c = 0;
      while (!get_tx_packet_data && c < 300) begin
         tx_packet = (c == 4) ? 2'b11 : 2'b00;
         @(negedge clk);
         c++;
      end
      tx_packet = 2'b00;
      check("busy_first_pop_cycle", c, 63);
      check("busy_active_at_pop", tx_transfer_active, 1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_lines_J", {dplus_out, dminus_out}, SYM_J);
      check("midrst_active", tx_transfer_active, 0);
      check("midrst_pop", get_tx_packet_data, 0);
      rst = 1'b0;
      pops_after = 0;
      active_after = 0;
      non_j = 0;
      repeat (150) begin
         @(negedge clk);
         if (get_tx_packet_data) pops_after++;
         if (tx_transfer_active) active_after++;
         if ({dplus_out, dminus_out} != SYM_J) non_j++;
      end
      check("midrst_extra_pops", pops_after, 0);
      check("midrst_active_after", active_after, 0);
      check("midrst_lines_stay_J", non_j, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
